// File: rtl/button_test_circuit_if.sv
`default_nettype none
// ============================================================================
// Module   : button_test_circuit_if
// Brief    : Button-in / event-count bundle between a board pin driver and
//            the button test circuit.
// Revision : 1.0
// ============================================================================
interface button_test_circuit_if #(
    parameter int BITS = 4
);
    logic            button_in;
    logic [BITS-1:0] Noisy_count;
    logic [BITS-1:0] Debounced_count;

    modport master (
        output button_in,
        input  Noisy_count,
        input  Debounced_count
    );

    modport slave (
        input  button_in,
        output Noisy_count,
        output Debounced_count
    );
endinterface
`default_nettype wire

// File: rtl/button_test_circuit.sv
`default_nettype none
// ============================================================================
// Module   : button_test_circuit
// Brief    : Synchronises and debounces a push-button, counting raw and
//            debounced rising edges so contact bounce becomes visible.
// Revision : 1.0
// ============================================================================
module button_test_circuit #(
    parameter int BITS            = 4,
    parameter int DEBOUNCE_CYCLES = 2_000_000
) (
    input  wire logic            clk,
    input  wire logic            reset,
    button_test_circuit_if.slave bus
);
    localparam logic [1:0]      c_ZERO  = 2'd0;
    localparam logic [1:0]      c_WAIT1 = 2'd1;
    localparam logic [1:0]      c_ONE   = 2'd2;
    localparam logic [1:0]      c_WAIT0 = 2'd3;
    // Timer starts at 0 on the first cycle of the new level, so the last
    // qualifying cycle sees DEBOUNCE_CYCLES-2 before stepping to the terminal.
    localparam logic [23:0]     c_TERM  = 24'(DEBOUNCE_CYCLES - 2);
    localparam logic [BITS-1:0] c_INC   = BITS'(1);

    logic            sync1_q, sync2_q, sync_prev_q;
    logic            db_prev_q;
    logic            noisy_pulse_q, db_pulse_q;
    logic [1:0]      state_q, state_d;
    logic [23:0]     timer_q, timer_d;
    logic [BITS-1:0] noisy_cnt_q, db_cnt_q;
    logic            w_db;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            c_ZERO: begin
                if (sync2_q) begin
                    timer_d = '0;
                    state_d = c_WAIT1;
                end
            end
            c_WAIT1: begin
                if (!sync2_q) begin
                    state_d = c_ZERO;
                end else begin
                    timer_d = timer_q + 24'd1;
                    if (timer_q == c_TERM) state_d = c_ONE;
                end
            end
            c_ONE: begin
                if (!sync2_q) begin
                    timer_d = '0;
                    state_d = c_WAIT0;
                end
            end
            c_WAIT0: begin
                if (sync2_q) begin
                    state_d = c_ONE;
                end else begin
                    timer_d = timer_q + 24'd1;
                    if (timer_q == c_TERM) state_d = c_ZERO;
                end
            end
            default: state_d = c_ZERO;
        endcase
    end

    assign w_db = (state_q == c_ONE) || (state_q == c_WAIT0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync_prev_q   <= 1'b0;
            db_prev_q     <= 1'b0;
            noisy_pulse_q <= 1'b0;
            db_pulse_q    <= 1'b0;
            state_q       <= c_ZERO;
            timer_q       <= '0;
            noisy_cnt_q   <= '0;
            db_cnt_q      <= '0;
        end else begin
            sync1_q       <= bus.button_in;
            sync2_q       <= sync1_q;
            sync_prev_q   <= sync2_q;
            db_prev_q     <= w_db;
            // Edge pulses are registered so each counter steps one clock after its rise.
            noisy_pulse_q <= sync2_q & ~sync_prev_q;
            db_pulse_q    <= w_db & ~db_prev_q;
            state_q       <= state_d;
            timer_q       <= timer_d;
            if (noisy_pulse_q) noisy_cnt_q <= noisy_cnt_q + c_INC;
            if (db_pulse_q)    db_cnt_q    <= db_cnt_q + c_INC;
        end
    end

    assign bus.Noisy_count     = noisy_cnt_q;
    assign bus.Debounced_count = db_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_button_test_circuit.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_test_circuit
// Brief    : Scoreboard bench for button_test_circuit (scaled debounce times).
// Revision : 1.0
// ============================================================================
module tb_button_test_circuit;
    localparam int c_DC   = 16;   // main instance debounce length
    localparam int c_DC_W = 8;    // wrap instance debounce length
    localparam int c_HOLD = 60;   // well beyond qualification
    localparam int c_TOG  = 4;    // bounce period, shorter than qualification

    logic clk;
    logic reset;

    button_test_circuit_if #(.BITS(4)) bus_a ();
    button_test_circuit_if #(.BITS(2)) bus_b ();

    button_test_circuit #(.BITS(4), .DEBOUNCE_CYCLES(c_DC)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    button_test_circuit #(.BITS(2), .DEBOUNCE_CYCLES(c_DC_W)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    noisy;
        int    deb;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input int n, input int d);
        exp_t e;
        e.tag   = tag;
        e.noisy = n;
        e.deb   = d;
        exp_q.push_back(e);
    endtask

    task automatic pop_a();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, "_noisy"}, 32'(bus_a.Noisy_count), 32'(e.noisy));
            chk({e.tag, "_deb"}, 32'(bus_a.Debounced_count), 32'(e.deb));
        end
    endtask

    task automatic pop_b();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, "_noisy"}, 32'(bus_b.Noisy_count), 32'(e.noisy));
            chk({e.tag, "_deb"}, 32'(bus_b.Debounced_count), 32'(e.deb));
        end
    endtask

    task automatic toggles(input int n);
        for (int i = 0; i < n; i++) begin
            bus_a.button_in = ~bus_a.button_in;
            cyc(c_TOG);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_lat;
        int d_lat;
        logic [3:0] n0;
        logic [3:0] d0;

        reset           = 1'b1;
        bus_a.button_in = 1'b0;
        bus_b.button_in = 1'b0;
        push_exp("reset", 0, 0);
        cyc(3);
        pop_a();
        reset = 1'b0;

        // Press, then reset asynchronously while the debouncer is qualifying.
        bus_a.button_in = 1'b1;
        push_exp("pre_rst", 1, 0);
        cyc(10);
        pop_a();
        #2 reset = 1'b1;
        push_exp("rst_async", 0, 0);
        #1 pop_a();
        push_exp("rst_held", 0, 0);
        cyc(3);
        pop_a();
        reset = 1'b0;
        push_exp("held_thru_rst", 1, 1);
        cyc(c_HOLD);
        pop_a();
        bus_a.button_in = 1'b0;
        cyc(c_HOLD);
        reset = 1'b1;
        push_exp("reclear", 0, 0);
        cyc(2);
        pop_a();
        reset = 1'b0;
        cyc(2);

        // Clean press with latency measurement.
        n0    = bus_a.Noisy_count;
        d0    = bus_a.Debounced_count;
        n_lat = 0;
        d_lat = 0;
        bus_a.button_in = 1'b1;
        for (int i = 1; i <= c_DC + 20; i++) begin
            cyc(1);
            if (n_lat == 0 && bus_a.Noisy_count != n0) n_lat = i;
            if (bus_a.Debounced_count != d0) begin
                d_lat = i;
                break;
            end
        end
        chk("noisy_latency", 32'(n_lat), 32'd4);
        chk("deb_latency", 32'(d_lat), 32'(c_DC + 4));
        push_exp("clean_press", 1, 1);
        cyc(c_HOLD);
        pop_a();
        bus_a.button_in = 1'b0;
        push_exp("clean_release", 1, 1);
        cyc(c_HOLD);
        pop_a();

        push_exp("bouncy_press", 4, 2);
        toggles(5);
        cyc(c_HOLD);
        pop_a();
        push_exp("bouncy_release", 6, 2);
        toggles(5);
        cyc(c_HOLD);
        pop_a();

        push_exp("glitch_low", 9, 2);
        toggles(6);
        cyc(c_HOLD);
        pop_a();

        bus_a.button_in = 1'b1;
        push_exp("press_before_glitch", 10, 3);
        cyc(c_HOLD);
        pop_a();
        push_exp("glitch_high", 13, 3);
        toggles(6);
        cyc(c_HOLD);
        pop_a();
        bus_a.button_in = 1'b0;
        push_exp("final_release", 13, 3);
        cyc(c_HOLD);
        pop_a();

        // Narrow instance: five clean presses wrap both counters.
        for (int i = 1; i <= 5; i++) begin
            bus_b.button_in = 1'b1;
            push_exp($sformatf("wrap%0d", i), i % 4, i % 4);
            cyc(30);
            bus_b.button_in = 1'b0;
            cyc(30);
            pop_b();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/button_test_circuit.md
Name: button_test_circuit

Overview:
- Test harness block for a push-button front end: synchronises a raw mechanical button input and debounces it.
- Keeps two wrapping event counters: rising edges of the raw synchronised button (Noisy_count) and rising edges of the debounced button (Debounced_count).
- Sits between a board push-button pin and LEDs or 7-segment displays; comparing the two counts shows contact bounce.

Parameters:
- BITS, 4, width of both counters.
- DEBOUNCE_CYCLES, 2_000_000, number of consecutive stable clock cycles required to accept a level change (20 ms at 100 MHz); legal range 2 to 2^24-1.

Ports:
- clk  input  1  system clock, 100 MHz nominal, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- button_in  input  1  raw asynchronous button level, 1 = pressed.
- Noisy_count  output  BITS  count of synchronised raw rising edges, modulo 2^BITS.
- Debounced_count  output  BITS  count of debounced rising edges, modulo 2^BITS.

Behaviour:
- Synchroniser: two-flop chain on button_in producing sync. Reset value 0.
- Noisy edge detect: register sync_d <= sync; noisy_rise = sync & ~sync_d.
- Noisy_count increments by 1 on the clock after noisy_rise and wraps from 2^BITS-1 to 0.
- Latency: an input rising edge meeting setup before clock edge k increments Noisy_count at edge k+3.
- Debouncer FSM, 4 states, reset state ZERO, with a 24-bit timer:
  - ZERO: db=0. If sync=1, clear the timer and go to WAIT1.
  - WAIT1: db=0. If sync=0, go to ZERO. Otherwise increment the timer; when the timer reaches DEBOUNCE_CYCLES-1 with sync still 1, go to ONE.
  - ONE: db=1. If sync=0, clear the timer and go to WAIT0.
  - WAIT0: db=1. If sync=1, go to ONE. Otherwise increment the timer; when it reaches DEBOUNCE_CYCLES-1, go to ZERO.
- The debounced level changes only after exactly DEBOUNCE_CYCLES consecutive cycles of the new sync level. Any glitch restarts qualification from the stable state.
- Debounced edge: db_d register; db_rise = db & ~db_d. Debounced_count increments on the clock after db_rise and wraps modulo 2^BITS.
- Falling edges never change either counter.
- Reset (asynchronous, at any time, including mid-qualification):
  - Synchroniser flops, sync_d, FSM (to ZERO), timer, db_d and both counters go to 0 at once.
  - Outputs read 0 while reset=1.
  - Button held high through reset release: counts as one noisy rise, and one debounced rise after qualification.
- Counters are independent; simultaneous increments in the same cycle are both taken.

Test Plan:
All cases use 100 MHz clk, reset pulsed at start and default parameters; counts are cumulative.
1. Reset asserted -> both outputs 0; reset applied mid-WAIT1 -> FSM returns to ZERO and the counts clear.
2. Clean press held 50 ms, then released 50 ms -> Noisy_count=1, Debounced_count=1. Debounced_count rises exactly DEBOUNCE_CYCLES+4 cycles after the input edge, ±1 for synchroniser phase.
3. Bouncy press (5 toggles at 1.25 ms ending high, hold 25 ms) -> Noisy=4, Debounced=2. Then bouncy release (5 toggles ending low) -> Noisy=6, Debounced=2.
4. Glitch train while low (6 toggles at 1.25 ms ending low) -> Noisy=9, Debounced=2; debounced level never leaves 0.
5. Clean press, then 6 toggles at 1.25 ms while high, then release -> Noisy=13, Debounced=3; debounced level never drops during the glitches.
6. Wrap-around with BITS=2, DEBOUNCE_CYCLES=8: 5 clean presses -> both counts read 1 (5 mod 4).
